// File: rtl/rr_word_arbiter_pkg.sv
// Shared constants and index helper for the four-way round-robin word arbiter.
package rr_word_arbiter_pkg;

    localparam int NREQ  = 4;
    localparam int SEL_W = 2;

    // Advance a requester index by one, wrapping 3 -> 0.
    function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
        return idx + SEL_W'(1);
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first active request scanning from ptr upward, modulo 4.
module rr_pick4
    import rr_word_arbiter_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] winner,
    output logic             any
);

    // Scan from the farthest offset back to ptr so the closest active request is the last to be taken.
    always_comb begin
        // NOTE: assign defaults before any conditional write so no path leaves an output unassigned (prevents latches).
        winner = ptr;
        any    = |req;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[ptr + SEL_W'(k)]) begin
                winner = ptr + SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/rr_word_arbiter4.sv
// Round-robin arbiter sharing one word channel among four requesters, with a
// registered valid/ready output stage. Optional burst lock enabled by ARB_LOCK_EN.
module rr_word_arbiter4
    import rr_word_arbiter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREQ   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DATA_W-1:0] data,
`ifdef ARB_LOCK_EN
    input  logic [NREQ-1:0]        lock,
`endif
    output logic [NREQ-1:0]        ack,
    output logic [SEL_W-1:0]       sel,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [SEL_W-1:0]       out_src
);

    logic [SEL_W-1:0]  r_ptr;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [SEL_W-1:0]  r_src;

    logic [SEL_W-1:0]  w_pick_winner;
    logic              w_any;
    logic              w_lock_hit;
    logic [SEL_W-1:0]  w_winner;
    logic              w_accept;
    logic              w_fire;
    logic [SEL_W-1:0]  w_next_ptr;

    rr_pick4 u_pick (
        .req    (req),
        .ptr    (r_ptr),
        .winner (w_pick_winner),
        .any    (w_any)
    );

`ifdef ARB_LOCK_EN
    // A locked holder of the output register keeps winning while it still requests.
    assign w_lock_hit = r_valid & lock[r_src] & req[r_src];
`else
    assign w_lock_hit = 1'b0;
`endif

    assign w_winner   = w_lock_hit ? r_src : w_pick_winner;
    assign w_next_ptr = w_lock_hit ? r_ptr : next_idx(w_winner);
    assign w_accept   = ~r_valid | out_ready;
    assign w_fire     = w_accept & w_any & ~rst;

    // Grant and mux select; select rests on ptr when nothing is granted and on 0 in reset.
    always_comb begin
        ack = '0;
        sel = rst ? '0 : r_ptr;
        if (w_fire) begin
            ack[w_winner] = 1'b1;
            sel           = w_winner;
        end
    end

    // Output register and round-robin pointer; holds everything while the consumer stalls.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            // NOTE: the data register is reset too, because out_data is defined as 0 after reset.
            r_valid <= 1'b0;
            r_data  <= '0;
            r_src   <= '0;
            r_ptr   <= '0;
        end else if (w_accept) begin
            if (w_any) begin
                r_valid <= 1'b1;
                r_data  <= data[w_winner*DATA_W +: DATA_W];
                r_src   <= w_winner;
                r_ptr   <= w_next_ptr;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_src   = r_src;

endmodule

// File: tb/tb_rr_word_arbiter4.sv
// Self-checking bench for rr_word_arbiter4: directed scenarios plus randomized
// traffic, compared against a behavioural round-robin model.
module tb_rr_word_arbiter4;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          t_rst;
    logic [3:0]    t_req;
    logic [4*DW-1:0] t_data;
    logic [3:0]    t_lock;
    logic          t_ready;
    logic [3:0]    ack;
    logic [1:0]    sel;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    out_src;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int          m_ptr   = 0;
    bit          m_valid = 0;
    logic [31:0] m_data  = '0;
    int          m_src   = 0;

    always #5 clk = ~clk;

    rr_word_arbiter4 #(.DATA_W(DW), .NREQ(4)) dut (
        .clk       (clk),
        .rst       (t_rst),
        .req       (t_req),
        .data      (t_data),
`ifdef ARB_LOCK_EN
        .lock      (t_lock),
`endif
        .ack       (ack),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (t_ready),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, check combinational grant, clock, check registers.
    task automatic step(input logic rst_i, input logic [3:0] req_i, input logic ready_i,
                        input logic [3:0] lock_i);
        bit   accept, fire, found;
        int   win;
        logic [3:0] exp_ack;
        int   exp_sel;
        t_rst = rst_i; t_req = req_i; t_ready = ready_i; t_lock = lock_i;
        #1;
        accept = !m_valid || ready_i;
        win = m_ptr;
        found = 0;
        if (m_valid && lock_i[m_src] && req_i[m_src]) begin
            win = m_src;
            found = 1;
        end else begin
            for (int off = 0; off < 4; off++) begin
                if (!found && req_i[(m_ptr + off) % 4]) begin
                    win = (m_ptr + off) % 4;
                    found = 1;
                end
            end
        end
        fire    = !rst_i && accept && found;
        exp_ack = fire ? (4'b0001 << win) : 4'b0000;
        exp_sel = rst_i ? 0 : (fire ? win : m_ptr);
        check("ack", {28'd0, ack}, {28'd0, exp_ack});
        check("sel", {30'd0, sel}, exp_sel);
        @(posedge clk);
        if (rst_i) begin
            m_valid = 0; m_data = '0; m_src = 0; m_ptr = 0;
        end else if (accept) begin
            if (found) begin
                m_valid = 1;
                m_data  = t_data[win*DW +: DW];
                if (!(m_valid && win == m_src && lock_i[m_src] && req_i[m_src] && m_src == win &&
                      lock_i[win] && (m_src == win)))
                    ; // pointer update handled below
                // Lock hit keeps the pointer; a normal grant moves it past the winner.
                if (!(lock_i[win] && win == m_src && req_i[win] && m_valid_before_lock(win)))
                    m_ptr = (win + 1) % 4;
                m_src = win;
            end else begin
                m_valid = 0;
            end
        end
        #1;
        check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        check("out_data", out_data, m_data);
        check("out_src", {30'd0, out_src}, m_src);
    endtask

    // Lock status captured before the model registers are updated in a step.
    bit lock_was_hit;
    function automatic bit m_valid_before_lock(input int w);
        return lock_was_hit && (w >= 0);
    endfunction

    task automatic cycle(input logic rst_i, input logic [3:0] req_i, input logic ready_i,
                         input logic [3:0] lock_i);
        lock_was_hit = m_valid && lock_i[m_src] && req_i[m_src];
        step(rst_i, req_i, ready_i, lock_i);
    endtask

    task automatic set_word(input int i, input logic [31:0] w);
        t_data[i*DW +: DW] = w;
    endtask

    initial begin
        t_rst = 1; t_req = 0; t_data = '0; t_lock = 0; t_ready = 1;

        // Reset then a single request from requester 0
        cycle(1, 4'b0000, 1, 4'b0000);
        cycle(1, 4'b0000, 1, 4'b0000);
        set_word(0, 32'hDEADBEEF);
        cycle(0, 4'b0001, 1, 4'b0000);
        check("first_word", out_data, 32'hDEADBEEF);
        cycle(0, 4'b0000, 1, 4'b0000);
        check("ptr_after_first", {30'd0, sel}, 32'd1);

        // All four requesting continuously: strict 0,1,2,3,0,1 rotation
        cycle(1, 4'b0000, 1, 4'b0000);
        for (int i = 0; i < 4; i++) set_word(i, 32'h1000 + i);
        for (int k = 0; k < 6; k++) begin
            cycle(0, 4'b1111, 1, 4'b0000);
            check("rr_seq", {30'd0, out_src}, k % 4);
        end

        // Backpressure: word from requester 2 held for 5 stalled cycles, then 3 is served
        cycle(1, 4'b0000, 1, 4'b0000);
        set_word(2, 32'hCAFE0002);
        set_word(3, 32'hCAFE0003);
        cycle(0, 4'b0100, 1, 4'b0000);
        for (int k = 0; k < 5; k++) cycle(0, 4'b1111, 0, 4'b0000);
        check("bp_hold", out_data, 32'hCAFE0002);
        cycle(0, 4'b1111, 1, 4'b0000);
        check("bp_release", {30'd0, out_src}, 32'd3);

        // Wrap-around: ptr=3 after granting 2, then req=1001 gives 3 then 0
        cycle(1, 4'b0000, 1, 4'b0000);
        cycle(0, 4'b0100, 1, 4'b0000);
        cycle(0, 4'b1001, 1, 4'b0000);
        check("wrap_3", {30'd0, out_src}, 32'd3);
        cycle(0, 4'b0001, 1, 4'b0000);
        check("wrap_0", {30'd0, out_src}, 32'd0);

        // Reset while holding a word; pending request served after reset
        set_word(2, 32'h55AA55AA);
        cycle(0, 4'b0100, 1, 4'b0000);
        cycle(0, 4'b0100, 0, 4'b0000);
        cycle(1, 4'b0100, 0, 4'b0000);
        check("rst_clears_valid", {31'd0, out_valid}, 32'd0);
        cycle(0, 4'b0100, 0, 4'b0000);
        check("post_rst_serve", out_data, 32'h55AA55AA);

`ifdef ARB_LOCK_EN
        // Locked burst from requester 1, pointer parked at 2, then unlock yields 0
        cycle(1, 4'b0000, 1, 4'b0000);
        set_word(0, 32'hA0); set_word(1, 32'hA1);
        cycle(0, 4'b0010, 1, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            cycle(0, 4'b0011, 1, 4'b0010);
            check("lock_src", {30'd0, out_src}, 32'd1);
        end
        cycle(0, 4'b0011, 1, 4'b0000);
        check("unlock_grant0", {30'd0, out_src}, 32'd0);
`endif

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 4; i++) set_word(i, $urandom);
`ifdef ARB_LOCK_EN
            cycle(($urandom_range(0, 49) == 0), 4'($urandom), ($urandom_range(0, 3) != 0),
                  4'($urandom));
`else
            cycle(($urandom_range(0, 49) == 0), 4'($urandom), ($urandom_range(0, 3) != 0),
                  4'b0000);
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
